// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory load controller.
package imem_pkg;

  localparam int unsigned MEM_BYTES_DEFAULT = 128;
  localparam int unsigned WORD_BYTES        = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FLUSH = 3'd2,
    S_RUN   = 3'd3,
    S_ERR   = 3'd4
  } state_t;

endpackage

// File: rtl/imem_fetch_guard.sv
// Fetch address guard: forwards the PC to the memory read port while the core
// runs and flags misaligned or out-of-range fetches.
module imem_fetch_guard
  import imem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int unsigned AW        = 32
) (
  input  logic          i_run,
  input  logic [AW-1:0] i_pc,
  output logic          o_fault,
  output logic [AW-1:0] o_raddr
);

  localparam logic [AW:0] LP_LIMIT = (AW+1)'(MEM_BYTES);
  localparam logic [AW:0] LP_OFS   = (AW+1)'(WORD_BYTES - 1);

  logic [AW:0] w_end;
  logic        w_misalign;
  logic        w_range;

  // Last byte of the fetched word, one bit wider so pc near 2^AW cannot wrap
  always_comb begin
    w_end      = {1'b0, i_pc} + LP_OFS;
    w_misalign = (i_pc[1:0] != 2'b00);
    w_range    = (w_end >= LP_LIMIT);
    o_fault    = i_run && (w_misalign || w_range);
    o_raddr    = i_run ? i_pc : '0;
  end

endmodule

// File: rtl/imem_load_ctrl.sv
// Boot/reload controller: streams bytes from a valid/ready loader into the
// instruction memory, stalls the core while loading, then releases it.
// Optional macro IMEM_LOAD_CHKSUM_EN: the ld_last byte is a modulo-256
// checksum of the payload, not written, and verified before release.
module imem_load_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT,
  parameter int unsigned AW        = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load_start,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  input  logic          ld_last,
  output logic          ld_ready,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [7:0]    mem_wdata,
  input  logic [AW-1:0] fetch_pc,
  output logic [AW-1:0] mem_raddr,
  output logic          core_run,
  output logic          fetch_fault,
  output logic          load_done,
  output logic          load_err,
  output logic [AW-1:0] byte_count
);

  localparam logic [AW-1:0] LP_MEM_BYTES = AW'(MEM_BYTES);

`ifdef IMEM_LOAD_CHKSUM_EN
  localparam logic LP_CHK = 1'b1;
`else
  localparam logic LP_CHK = 1'b0;
`endif

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_start;
  logic          w_write;
  logic          w_ovf;
  logic          w_aligned;
  logic          w_sum_ok;
  logic          w_run;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_waddr;
  logic [7:0]    r_mem_wdata;
  logic [AW-1:0] r_byte_count;
  logic          r_load_done;
  logic          r_load_err;

`ifdef IMEM_LOAD_CHKSUM_EN
  logic [7:0] r_sum;
  logic [7:0] r_chk_rx;

  // Running payload sum and captured checksum byte for the FLUSH compare
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sum    <= '0;
      r_chk_rx <= '0;
    end else begin
      if (w_start) begin
        r_sum <= '0;
      end else if (w_write) begin
        r_sum <= r_sum + ld_data;
      end
      if ((r_state == S_LOAD) && ld_valid && ld_last && !w_ovf) begin
        r_chk_rx <= ld_data;
      end
    end
  end

  assign w_sum_ok = (r_sum == r_chk_rx);
`else
  assign w_sum_ok = 1'b1;
`endif

  // The checksum byte is never stored, so it cannot overflow the memory
  assign w_ovf     = (r_byte_count == LP_MEM_BYTES) && !(LP_CHK && ld_last);
  assign w_aligned = ((r_byte_count % AW'(WORD_BYTES)) == '0);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and per-cycle control decode
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_write     = 1'b0;
    case (r_state)
      S_IDLE, S_RUN, S_ERR: begin
        if (load_start) begin
          w_start     = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (ld_valid) begin
          if (w_ovf) begin
            w_state_nxt = S_ERR;
          end else begin
            w_write = !(LP_CHK && ld_last);
            if (ld_last) begin
              w_state_nxt = S_FLUSH;
            end
          end
        end
      end
      S_FLUSH: begin
        if (!w_sum_ok) begin
          w_state_nxt = S_ERR;
        end else if (w_aligned) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_ERR;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered write port, byte counter and sticky status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mem_we     <= 1'b0;
      r_mem_waddr  <= '0;
      r_mem_wdata  <= '0;
      r_byte_count <= '0;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      r_mem_we <= w_write;
      if (w_start) begin
        r_byte_count <= '0;
        r_load_done  <= 1'b0;
        r_load_err   <= 1'b0;
      end else if (w_write) begin
        r_mem_waddr  <= r_byte_count;
        r_mem_wdata  <= ld_data;
        r_byte_count <= r_byte_count + AW'(1);
      end
      if ((r_state == S_FLUSH) && (w_state_nxt == S_RUN)) begin
        r_load_done <= 1'b1;
      end
      if ((w_state_nxt == S_ERR) && (r_state != S_ERR)) begin
        r_load_err <= 1'b1;
      end
    end
  end

  assign w_run      = (r_state == S_RUN);
  assign ld_ready   = (r_state == S_LOAD);
  assign core_run   = w_run;
  assign mem_we     = r_mem_we;
  assign mem_waddr  = r_mem_waddr;
  assign mem_wdata  = r_mem_wdata;
  assign byte_count = r_byte_count;
  assign load_done  = r_load_done;
  assign load_err   = r_load_err;

  imem_fetch_guard #(
    .MEM_BYTES (MEM_BYTES),
    .AW        (AW)
  ) u_fetch_guard (
    .i_run   (w_run),
    .i_pc    (fetch_pc),
    .o_fault (fetch_fault),
    .o_raddr (mem_raddr)
  );

endmodule
